vram_port_arbiter: RTL and testbench
====================================

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data width of one RAM word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, the RAM port-A word address width.
REQ-003 SHALL have parameter NREQ, default 4, the number of requesters (range 2..8).
REQ-004 SHALL have parameter MAX_BURST, default 8, the maximum number of back-to-back accesses per grant (range 1..255).
REQ-005 SHALL have parameter RD_LATENCY, default 2, the cycles from ram_address valid to ram_q valid.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset_sink_reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port req, input, NREQ bits: per-requester access request, held until granted.
REQ-009 SHALL have port we, input, NREQ bits: per-requester write (1) or read (0).
REQ-010 SHALL have port addr, input, NREQ*ADDR_WIDTH bits: flattened per-requester address, requester i at slice i.
REQ-011 SHALL have port wdata, input, NREQ*WIDTH bits: flattened per-requester write data.
REQ-012 SHALL have port gnt, output, NREQ bits: one-hot accept, combinational, high in the cycle the access is taken.
REQ-013 SHALL have port rvalid, output, NREQ bits: one-cycle pulse marking rdata valid for requester i.
REQ-014 SHALL have port rdata, output, WIDTH bits: read data, equal to ram_q.
REQ-015 SHALL have ports ram_address (output, ADDR_WIDTH), ram_data (output, WIDTH), ram_wren (output, 1) and ram_q (input, WIDTH), connecting to RAM port A.

Function
REQ-016 SHALL accept at most one access per cycle; gnt SHALL be zero or one-hot, and gnt[i] SHALL imply req[i].
REQ-017 SHALL have states IDLE (no owner) and OWNED (owner index, burst count).
REQ-018 IDLE -> OWNED SHALL occur on any req; the winner is the first requesting index after last_owner, searching round-robin upward with wrap-around.
REQ-019 In OWNED, the owner SHALL keep gnt while req[owner] is high and burst count < MAX_BURST; the counter increments on every accept.
REQ-020 When the owner drops req or the count reaches MAX_BURST, the arbiter SHALL re-arbitrate in the same cycle, excluding the old owner unless it is the sole requester; the count resets to 1 on the new grant.
REQ-021 OWNED -> IDLE SHALL occur when no req is high; last_owner SHALL be retained.
REQ-022 Accept in cycle T SHALL register addr, wdata and we of the winner onto ram_address, ram_data and ram_wren, valid in cycle T+1.
REQ-023 Without an accept, ram_wren SHALL be 0 next cycle, and ram_address and ram_data SHALL hold their values.
REQ-024 A read accepted in cycle T SHALL pulse rvalid[i] in cycle T+1+RD_LATENCY; writes SHALL produce no rvalid.
REQ-025 Reads SHALL be tracked in a (1+RD_LATENCY)-deep valid/index shift register, so a read can be accepted every cycle with no bubble.
REQ-026 Read-after-write to the same address from any requesters SHALL complete in accept order, with no reordering.

Reset
REQ-027 Asynchronous reset SHALL force IDLE, last_owner=NREQ-1, burst count=0, ram_wren=0, ram_address=0, ram_data=0, rvalid=0 and the tracking shift register cleared.
REQ-028 Reads in flight at reset SHALL be discarded, with no rvalid after reset release; gnt SHALL be 0 while reset is asserted.

Configuration
REQ-029 With VRAM_ARB_FIXED_PRIO_EN defined, requester 0 SHALL win whenever req[0] is high, pre-empting any burst the same cycle; its bursts are unlimited, and other requesters still rotate round-robin among themselves.
REQ-030 Without VRAM_ARB_FIXED_PRIO_EN, all requesters SHALL be equal under REQ-018..REQ-020.

Structure
REQ-031 Package vram_arb_pkg SHALL hold the state enum, the default WIDTH, ADDR_WIDTH and RD_LATENCY constants, and a clog2 function.
REQ-032 Sub-module vram_arb_rr_pick SHALL compute the combinational rotating-priority one-hot pick from a request vector and a start index.

Verification
REQ-033 Requesters 0..3 read continuously with MAX_BURST=2 -> grant order 0,0,1,1,2,2,3,3,0; rvalid follows each accept by exactly 3 cycles.
REQ-034 Requester 2 writes 0xDEADBEEF to 0x0010, then requester 1 reads 0x0010 -> rvalid[1] with rdata=0xDEADBEEF.
REQ-035 Assert reset 1 cycle after three reads are accepted -> no rvalid is ever seen; all outputs are 0; the next grant after release goes to the lowest requesting index.
REQ-036 Owner 1 drops req mid-burst while req[3] is high -> gnt[3] in the same cycle.
REQ-037 With VRAM_ARB_FIXED_PRIO_EN defined, req[0] rises during requester 2's burst -> gnt[0] that cycle, and it persists for more than MAX_BURST accesses.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared state type, default sizes and clog2 helper for the VRAM port arbiter
package vram_arb_pkg;
  typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_e;
  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_RD_LATENCY = 2;
  function automatic int clog2(input int n);
    for (int r = 0; r < 32; r++) if ((1 << r) >= n) return r;
    return 32;
  endfunction
endpackage

// File: rtl/vram_arb_rr_pick.sv
// vram_arb_rr_pick: combinational rotating-priority one-hot pick
//   req_i   : request vector
//   start_i : index given highest priority; search proceeds upward with wrap
//   gnt_o   : one-hot pick, zero when no request
module vram_arb_rr_pick
  import vram_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o
);
  // walk from lowest to highest priority so the last hit (start_i itself) wins
  always_comb begin
    gnt_o = '0;
    for (int k = N - 1; k >= 0; k--)
      if (|(req_i & (N'(1) << ((int'(start_i) + k) % N)))) gnt_o = N'(1) << ((int'(start_i) + k) % N);
  end
endmodule

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: round-robin burst arbiter sharing one VRAM port A among NREQ requesters
//   clk, reset_sink_reset (async, active high)
//   req/we/addr/wdata : per-requester access, flattened, requester i at slice i
//   gnt               : combinational one-hot accept
//   rvalid/rdata      : read return, rvalid[i] pulses 1+RD_LATENCY cycles after accept
//   ram_address/ram_data/ram_wren/ram_q : RAM port A
// Optional: VRAM_ARB_FIXED_PRIO_EN gives requester 0 absolute, unlimited-burst priority.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NREQ       = 4,
  parameter int MAX_BURST  = 8,
  parameter int RD_LATENCY = DEF_RD_LATENCY
) (
  input  logic                       clk,
  input  logic                       reset_sink_reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*WIDTH-1:0]      wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [WIDTH-1:0]           rdata,
  output logic [ADDR_WIDTH-1:0]      ram_address,
  output logic [WIDTH-1:0]           ram_data,
  output logic                       ram_wren,
  input  logic [WIDTH-1:0]           ram_q
);
  localparam int IW = clog2(NREQ);
  localparam int D  = 1 + RD_LATENCY;
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
  state_e                state_q;
  logic [IW-1:0]         owner_q, last_q, start, win;
  logic [7:0]            cnt_q;
  logic                  keep, acc, sel_we;
  logic [NREQ-1:0]       own_oh, rr_req, pick, gnt_c;
  logic [ADDR_WIDTH-1:0] addr_q, sel_addr;
  logic [WIDTH-1:0]      data_q, sel_data;
  logic                  wren_q;
  logic [D-1:0]          rv_q;
  logic [IW-1:0]         ri_q [D];
  assign own_oh = NREQ'(1) << owner_q;
  assign keep   = state_q == OWNED && |(req & own_oh) && cnt_q < 8'(MAX_BURST);
  // searching from last_q+1 puts the previous owner last, so it only re-wins when alone
  assign start  = last_q == LAST ? '0 : last_q + IW'(1);
`ifdef VRAM_ARB_FIXED_PRIO_EN
  assign rr_req = req & ~NREQ'(1);
  assign gnt_c  = req[0] ? NREQ'(1) : keep ? own_oh : pick;
`else
  assign rr_req = req;
  assign gnt_c  = keep ? own_oh : pick;
`endif
  vram_arb_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i  (rr_req),
    .start_i(start),
    .gnt_o  (pick)
  );
  assign gnt = reset_sink_reset ? '0 : gnt_c;
  assign acc = |gnt_c;
  always_comb begin
    win      = '0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt_c[i]) begin
        win      = IW'(i);
        sel_we   = we[i];
        sel_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = wdata[i*WIDTH +: WIDTH];
      end
  end
  always_ff @(posedge clk or posedge reset_sink_reset)
    if (reset_sink_reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      rv_q    <= '0;
      for (int k = 0; k < D; k++) ri_q[k] <= '0;
    end else begin
      state_q <= acc ? OWNED : IDLE;
      cnt_q   <= !acc ? 8'd0 : keep && win == owner_q ? cnt_q + 8'd1 : 8'd1;
      wren_q  <= acc && sel_we;
      rv_q[0] <= acc && !sel_we;
      ri_q[0] <= win;
      for (int k = 1; k < D; k++) begin
        rv_q[k] <= rv_q[k-1];
        ri_q[k] <= ri_q[k-1];
      end
      if (acc) begin
        owner_q <= win;
        addr_q  <= sel_addr;
        data_q  <= sel_data;
      end
`ifdef VRAM_ARB_FIXED_PRIO_EN
      // requester 0 sits outside the rotation, so it never moves the pointer
      if (acc && win != '0) last_q <= win;
`else
      if (acc) last_q <= win;
`endif
    end
  assign ram_address = addr_q;
  assign ram_data    = data_q;
  assign ram_wren    = wren_q;
  assign rvalid      = rv_q[D-1] ? NREQ'(1) << ri_q[D-1] : '0;
  assign rdata       = ram_q;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed stimulus checked every cycle against a behavioural arbiter/RAM model
module tb_vram_port_arbiter;
  localparam int N = 4, AW = 16, W = 32, MB = 2, RL = 2;
  logic clk = 0, rst = 0;
  logic [N-1:0] req = '0, we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0] gnt, rvalid;
  logic [W-1:0] rdata, ram_data, ram_q = '0, q1 = '0;
  logic [AW-1:0] ram_address;
  logic ram_wren;
  logic [W-1:0] mem [256];
  logic [W-1:0] smem [256];
  int total = 0, bad = 0, cyc = 0, rv_seen = 0;
  int own = -1, cnt = 0, last = N - 1, lastnz = N - 1;
  logic [AW-1:0] e_addr = '0;
  logic [W-1:0] e_data = '0;
  logic e_wren = 0;
  typedef struct {int due; int idx; logic [W-1:0] d;} rd_t;
  rd_t pend[$];
  int glog[$], gcyc[$], rcyc[$];
  logic [W-1:0] last_rd [N];

  vram_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .NREQ(N), .MAX_BURST(MB), .RD_LATENCY(RL)) dut (
    .clk(clk), .reset_sink_reset(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wren) mem[ram_address[7:0]] <= ram_data;
    q1    <= mem[ram_address[7:0]];
    ram_q <= q1;
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic int rr_after(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) if (r[(after + k) % N]) return (after + k) % N;
    return -1;
  endfunction

  function automatic int model_win(input logic [N-1:0] r);
    logic [N-1:0] c;
    int ptr;
    if (r == 0) return -1;
`ifdef VRAM_ARB_FIXED_PRIO_EN
    if (r[0]) return 0;
    c = r & ~N'(1);
    ptr = lastnz;
    if (own > 0 && r[own] && cnt < MB) return own;
`else
    c = r;
    ptr = last;
    if (own >= 0 && r[own] && cnt < MB) return own;
`endif
    if (own >= 0 && (c & ~(N'(1) << own)) != 0) c = c & ~(N'(1) << own);
    return rr_after(c, ptr);
  endfunction

  always @(negedge clk) begin : cmp
    int w;
    logic [N-1:0] eg, erv;
    cyc++;
    if (rst) begin
      chk("rst_gnt", 64'(gnt), 0);
      chk("rst_out", 64'({rvalid, ram_wren, ram_address, ram_data}), 0);
      pend.delete();
      own = -1; cnt = 0; last = N - 1; lastnz = N - 1;
      e_addr = '0; e_data = '0; e_wren = 0;
    end else begin
      erv = (pend.size() != 0 && pend[0].due == cyc) ? N'(1) << pend[0].idx : '0;
      chk("rvalid", 64'(rvalid), 64'(erv));
      if (erv != 0) begin
        chk("rdata", 64'(rdata), 64'(pend[0].d));
        pend.pop_front();
      end
      if (rvalid != 0) begin
        rv_seen++;
        rcyc.push_back(cyc);
        for (int i = 0; i < N; i++) if (rvalid[i]) last_rd[i] = rdata;
      end
      chk("ram_wren", 64'(ram_wren), 64'(e_wren));
      chk("ram_address", 64'(ram_address), 64'(e_addr));
      chk("ram_data", 64'(ram_data), 64'(e_data));
      w = model_win(req);
      eg = w < 0 ? '0 : N'(1) << w;
      chk("gnt", 64'(gnt), 64'(eg));
      e_wren = 0;
      if (w < 0) begin
        own = -1;
        cnt = 0;
      end else begin
        cnt = (w == own && cnt < MB) ? cnt + 1 : 1;
        own = w;
        last = w;
        if (w != 0) lastnz = w;
        glog.push_back(w);
        gcyc.push_back(cyc);
        e_addr = addr[w*AW +: AW];
        e_data = wdata[w*W +: W];
        e_wren = we[w];
        if (we[w]) smem[e_addr[7:0]] = e_data;
        else pend.push_back('{cyc + 1 + RL, w, smem[e_addr[7:0]]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int i, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*W +: W] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int exp033 [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic [7:0] tbl [8] = '{8'hF0, 8'h5A, 8'h3C, 8'h81, 8'hFF, 8'h12, 8'hE7, 8'h66};
    logic [7:0] v;
    int rvs0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'hA500_0000 | i;
      smem[i] = 32'hA500_0000 | i;
    end
    for (int i = 0; i < N; i++) last_rd[i] = '0;
    #1 rst = 1;
    req = '1;
    @(negedge clk);
    chk("gnt_in_reset", 64'(gnt), 0);
    tick();
    tick();
    rst = 0;
    req = '0;
    tick();
`ifndef VRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) put(i, 0, AW'(16'h20 + i), '0);
    glog.delete(); gcyc.delete(); rcyc.delete();
    req = 4'b1111;
    repeat (9) tick();
    req = '0;
    repeat (5) tick();
    chk("rr_count", 64'(glog.size()), 9);
    chk("rv_count", 64'(rcyc.size()), 9);
    if (glog.size() >= 9 && rcyc.size() >= 9)
      for (int k = 0; k < 9; k++) begin
        chk("rr_order", 64'(glog[k]), 64'(exp033[k]));
        chk("rv_latency", 64'(rcyc[k] - gcyc[k]), 3);
      end
`endif
    last_rd[1] = '0;
    put(2, 1, 16'h0010, 32'hDEAD_BEEF);
    req = 4'b0100;
    tick();
    put(1, 0, 16'h0010, '0);
    req = 4'b0010;
    tick();
    req = '0;
    put(2, 0, 16'h0000, '0);
    repeat (5) tick();
    chk("raw_rdata", 64'(last_rd[1]), 64'h0000_0000_DEAD_BEEF);
    put(1, 0, 16'h0030, '0);
    put(3, 1, 16'h0031, 32'h1234_5678);
    req = 4'b0010;
    @(negedge clk);
    chk("own1", 64'(gnt), 64'(4'b0010));
    tick();
    req = 4'b1000;
    @(negedge clk);
    chk("drop_to3", 64'(gnt), 64'(4'b1000));
    tick();
    req = '0;
    tick();
    put(0, 0, 16'h0031, '0);
    req = 4'b0001;
    repeat (4) tick();
    req = '0;
    tick();
    for (int s = 0; s < 8; s++) begin
      v = tbl[s];
      for (int i = 0; i < N; i++) put(i, v[i], AW'(16'h40 + s % 3), W'(32'h1000 * s + i));
      req = v[7:4];
      tick();
    end
    req = '0;
    repeat (5) tick();
`ifdef VRAM_ARB_FIXED_PRIO_EN
    put(2, 0, 16'h0060, '0);
    put(0, 0, 16'h0061, '0);
    req = 4'b0100;
    @(negedge clk);
    chk("fp_own2", 64'(gnt), 64'(4'b0100));
    tick();
    req = 4'b0101;
    for (int k = 0; k < MB + 2; k++) begin
      @(negedge clk);
      chk("fp_prio0", 64'(gnt), 64'(4'b0001));
      tick();
    end
    req = '0;
    repeat (5) tick();
`endif
    for (int i = 0; i < N; i++) put(i, 0, AW'(16'h50 + i), '0);
    req = 4'b0111;
    repeat (3) tick();
    rst = 1;
    req = '0;
    rvs0 = rv_seen;
    @(negedge clk);
    chk("rst_all_zero", 64'({gnt, rvalid, ram_wren, ram_address, ram_data}), 0);
    tick();
    tick();
    put(2, 1, 16'h0070, 32'h0BAD_F00D);
    put(3, 1, 16'h0071, 32'h0000_0003);
    rst = 0;
    req = 4'b1100;
    @(negedge clk);
    chk("post_rst_lowest", 64'(gnt), 64'(4'b0100));
    tick();
    req = '0;
    repeat (6) tick();
    chk("no_rvalid_after_rst", 64'(rv_seen - rvs0), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
